// File: rtl/rvv_backend_vrf_wr_sched_pkg.sv
// Shared types and default sizing for the VRF write-port scheduler.
// RT2VRF_t is the writeback payload carried from requesters to the VRF write ports.
package rvv_backend_vrf_wr_sched_pkg;

    localparam int VLENB             = 16;
    localparam int NUM_RT_UOP        = 4;
    localparam int NUM_VRF_WR_REQ    = 6;
    localparam int VRF_WR_FIFO_DEPTH = 2;

    typedef struct packed {
        logic [4:0]           rt_index;
        logic [VLENB*8-1:0]   rt_data;
        logic [VLENB-1:0]     rt_strobe;
    } RT2VRF_t;

    function automatic logic [31:0] vreg_onehot(input logic [4:0] idx);
        vreg_onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/rvv_backend_vrf_wr_fifo.sv
// Per-requester writeback buffer: head visible the cycle after push, ready from current count only.
// Exposes every entry's valid bit and rt_index so the top can build the pending-vreg mask.
module rvv_backend_vrf_wr_fifo
    import rvv_backend_vrf_wr_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  RT2VRF_t                   push_dat_i,
    output logic                      rdy_o,
    input  logic                      pop_i,
    output logic                      head_vld_o,
    output RT2VRF_t                   head_dat_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [DEPTH-1:0]          ent_vld_o,
    output logic [DEPTH-1:0][4:0]     ent_idx_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    RT2VRF_t [DEPTH-1:0] mem_q;
    logic [PW-1:0]       wptr_q;
    logic [PW-1:0]       rptr_q;
    logic [CW-1:0]       cnt_q;
    logic                do_push;
    logic                do_pop;

    assign rdy_o      = cnt_q < CW'(DEPTH);
    assign head_vld_o = cnt_q != '0;
    assign head_dat_o = mem_q[rptr_q];
    assign count_o    = cnt_q;
    assign do_push    = push_i & rdy_o;
    assign do_pop     = pop_i & head_vld_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_dat_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Entry j is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PW-1:0] off;
        off       = '0;
        ent_vld_o = '0;
        ent_idx_o = '0;
        for (int j = 0; j < DEPTH; j++) begin
            off          = PW'(j) - rptr_q;
            ent_vld_o[j] = {1'b0, off} < cnt_q;
            ent_idx_o[j] = mem_q[j].rt_index;
        end
    end

endmodule

// File: rtl/rvv_backend_vrf_wr_sched.sv
// VRF write-port scheduler: buffers requester writebacks, grants up to NUM_WP per cycle round-robin
// without same-vreg strobe overlap, registers the write ports. VRF_WR_SCHED_PERF_EN adds perf counters.
module rvv_backend_vrf_wr_sched
    import rvv_backend_vrf_wr_sched_pkg::*;
#(
    parameter int NUM_REQ    = NUM_VRF_WR_REQ,
    parameter int NUM_WP     = NUM_RT_UOP,
    parameter int FIFO_DEPTH = VRF_WR_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  RT2VRF_t [NUM_REQ-1:0]     req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_WP-1:0]         wr_valid,
    output RT2VRF_t [NUM_WP-1:0]      wr_data,
    output logic [31:0]               pend_vreg,
    output logic                      sched_busy
`ifdef VRF_WR_SCHED_PERF_EN
    ,
    output logic [31:0]               perf_conflict_cnt,
    output logic [31:0]               perf_full_cnt
`endif
);

    localparam int RW = $clog2(NUM_REQ);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_REQ-1:0]                  head_vld;
    RT2VRF_t [NUM_REQ-1:0]               head_dat;
    logic [NUM_REQ-1:0][CW-1:0]          fifo_cnt;
    logic [NUM_REQ-1:0][FIFO_DEPTH-1:0]  ent_vld;
    logic [NUM_REQ-1:0][FIFO_DEPTH-1:0][4:0] ent_idx;
    logic [NUM_REQ-1:0]                  grant;

    logic [RW-1:0]           rr_q, rr_d;
    logic [NUM_WP-1:0]       wr_valid_q, wr_valid_d;
    RT2VRF_t [NUM_WP-1:0]    wr_data_q, wr_data_d;
    logic                    conflict;

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_fifo
        rvv_backend_vrf_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .clk        (clk),
            .rst        (rst),
            .push_i     (req_valid[r]),
            .push_dat_i (req_data[r]),
            .rdy_o      (req_ready[r]),
            .pop_i      (grant[r]),
            .head_vld_o (head_vld[r]),
            .head_dat_o (head_dat[r]),
            .count_o    (fifo_cnt[r]),
            .ent_vld_o  (ent_vld[r]),
            .ent_idx_o  (ent_idx[r])
        );
    end

    // Scan heads from rr_q; the k-th grant lands on port k. A deferred head never blocks later ones.
    always_comb begin
        int      i;
        int      used;
        logic    hv;
        logic    hit;
        RT2VRF_t h;
        i          = 0;
        used       = 0;
        hv         = 1'b0;
        hit        = 1'b0;
        h          = '0;
        grant      = '0;
        wr_valid_d = '0;
        wr_data_d  = '0;
        rr_d       = rr_q;
        conflict   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            i = int'(rr_q) + k;
            if (i >= NUM_REQ) i = i - NUM_REQ;
            hv = 1'b0;
            h  = '0;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (r == i) begin
                    hv = head_vld[r];
                    h  = head_dat[r];
                end
            end
            hit = 1'b0;
            for (int p = 0; p < NUM_WP; p++) begin
                if (p < used && wr_data_d[p].rt_index == h.rt_index &&
                    (wr_data_d[p].rt_strobe & h.rt_strobe) != '0) begin
                    hit = 1'b1;
                end
            end
            if (hv && used < NUM_WP) begin
                if (hit) begin
                    conflict = 1'b1;
                end else begin
                    for (int r = 0; r < NUM_REQ; r++) begin
                        if (r == i) grant[r] = 1'b1;
                    end
                    for (int p = 0; p < NUM_WP; p++) begin
                        if (p == used) begin
                            wr_data_d[p]  = h;
                            wr_valid_d[p] = h.rt_strobe != '0;
                        end
                    end
                    used = used + 1;
                    rr_d = (i + 1 == NUM_REQ) ? '0 : RW'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q       <= '0;
            wr_valid_q <= '0;
            wr_data_q  <= '0;
        end else begin
            rr_q       <= rr_d;
            wr_valid_q <= wr_valid_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_data  = wr_data_q;

    always_comb begin
        pend_vreg  = '0;
        sched_busy = |wr_valid_q;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (fifo_cnt[r] != '0) sched_busy = 1'b1;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                if (ent_vld[r][e]) pend_vreg = pend_vreg | vreg_onehot(ent_idx[r][e]);
            end
        end
        for (int p = 0; p < NUM_WP; p++) begin
            if (wr_valid_q[p]) pend_vreg = pend_vreg | vreg_onehot(wr_data_q[p].rt_index);
        end
    end

`ifdef VRF_WR_SCHED_PERF_EN
    logic [31:0] perf_conflict_q;
    logic [31:0] perf_full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict_q <= '0;
            perf_full_q     <= '0;
        end else begin
            if (conflict && !(&perf_conflict_q)) perf_conflict_q <= perf_conflict_q + 1'b1;
            if (|(req_valid & ~req_ready) && !(&perf_full_q)) perf_full_q <= perf_full_q + 1'b1;
        end
    end

    assign perf_conflict_cnt = perf_conflict_q;
    assign perf_full_cnt     = perf_full_q;
`endif

endmodule

// File: tb/tb_rvv_backend_vrf_wr_sched.sv
// Directed bench for the VRF write-port scheduler: reset, latency, arbitration, conflicts, backpressure, fairness.
module tb_rvv_backend_vrf_wr_sched;
    import rvv_backend_vrf_wr_sched_pkg::*;

    localparam int NR = 6;
    localparam int NW = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NR-1:0]        req_valid = '0;
    RT2VRF_t [NR-1:0]     req_data = '0;
    logic [NR-1:0]        req_ready;
    logic [NW-1:0]        wr_valid;
    RT2VRF_t [NW-1:0]     wr_data;
    logic [31:0]          pend_vreg;
    logic                 sched_busy;
`ifdef VRF_WR_SCHED_PERF_EN
    logic [31:0]          perf_conflict_cnt;
    logic [31:0]          perf_full_cnt;
`endif

    int total = 0;
    int bad   = 0;

    rvv_backend_vrf_wr_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .pend_vreg  (pend_vreg),
`ifdef VRF_WR_SCHED_PERF_EN
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_full_cnt     (perf_full_cnt),
`endif
        .sched_busy (sched_busy)
    );

    always #5 clk = ~clk;

    function automatic RT2VRF_t mk(input logic [4:0] idx, input logic [15:0] strb, input logic [31:0] tag);
        RT2VRF_t t;
        t.rt_index  = idx;
        t.rt_strobe = strb;
        t.rt_data   = {96'd0, tag};
        return t;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        req_valid = '0;
        req_data  = '0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (wr_valid !== 4'b0000) begin bad++; $display("FAIL reset_wr_valid got=%b want=0000", wr_valid); end
        total++; if (wr_data !== '0) begin bad++; $display("FAIL reset_wr_data got=%h want=0", wr_data); end
        total++; if (pend_vreg !== 32'h0) begin bad++; $display("FAIL reset_pend got=%h want=0", pend_vreg); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", sched_busy); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 6'h3F) begin bad++; $display("FAIL reset_ready got=%b want=111111", req_ready); end
`ifdef VRF_WR_SCHED_PERF_EN
        total++; if (perf_conflict_cnt !== 32'd0 || perf_full_cnt !== 32'd0) begin
            bad++; $display("FAIL reset_perf got=%0d/%0d want=0/0", perf_conflict_cnt, perf_full_cnt);
        end
`endif
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) req_data[i] = mk(5'(20 + i), 16'hFFFF, 32'(i));
        req_valid = 6'b000111;
        @(negedge clk);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        total++; if (wr_valid !== 4'b0000) begin bad++; $display("FAIL midrst_wr_valid got=%b want=0000", wr_valid); end
        total++; if (pend_vreg !== 32'h0) begin bad++; $display("FAIL midrst_pend got=%h want=0", pend_vreg); end
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", sched_busy); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 6'h3F) begin bad++; $display("FAIL midrst_ready got=%b want=111111", req_ready); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (wr_valid !== 4'b0000 || pend_vreg !== 32'h0) begin
                bad++; $display("FAIL midrst_stale cyc=%0d wr_valid=%b pend=%h want=0000/0", c, wr_valid, pend_vreg);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req_data[0] = mk(5'd5, 16'hFFFF, 32'h55);
        req_valid   = 6'b000001;
        @(negedge clk);
        req_valid = '0;
        total++; if (pend_vreg[5] !== 1'b1 || wr_valid !== 4'b0000) begin
            bad++; $display("FAIL single_buffered pend5=%b wr_valid=%b want=1/0000", pend_vreg[5], wr_valid);
        end
        @(negedge clk);
        total++; if (wr_valid !== 4'b0001) begin bad++; $display("FAIL single_wr_valid got=%b want=0001", wr_valid); end
        total++; if (wr_data[0].rt_index !== 5'd5) begin bad++; $display("FAIL single_idx got=%0d want=5", wr_data[0].rt_index); end
        total++; if (pend_vreg[5] !== 1'b1) begin bad++; $display("FAIL single_pend_on_port got=%b want=1", pend_vreg[5]); end
        @(negedge clk);
        total++; if (pend_vreg !== 32'h0 || wr_valid !== 4'b0000 || sched_busy !== 1'b0) begin
            bad++; $display("FAIL single_drain pend=%h wr_valid=%b busy=%b want=0/0000/0", pend_vreg, wr_valid, sched_busy);
        end
    endtask

    task automatic test_six();
        do_reset();
        for (int i = 0; i < NR; i++) req_data[i] = mk(5'(i + 1), 16'hFFFF, 32'(i));
        req_valid = 6'h3F;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        total++; if (wr_valid !== 4'b1111) begin bad++; $display("FAIL six_c1_valid got=%b want=1111", wr_valid); end
        for (int p = 0; p < NW; p++) begin
            total++; if (wr_data[p].rt_index !== 5'(p + 1)) begin
                bad++; $display("FAIL six_c1_port%0d idx got=%0d want=%0d", p, wr_data[p].rt_index, p + 1);
            end
        end
        @(negedge clk);
        total++; if (wr_valid !== 4'b0011 || wr_data[0].rt_index !== 5'd5 || wr_data[1].rt_index !== 5'd6) begin
            bad++; $display("FAIL six_c2 valid=%b idx0=%0d idx1=%0d want=0011/5/6", wr_valid, wr_data[0].rt_index, wr_data[1].rt_index);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        req_data[1] = mk(5'd8, 16'h00FF, 32'h11);
        req_data[2] = mk(5'd8, 16'h00FF, 32'h22);
        req_valid   = 6'b000110;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        total++; if (wr_valid !== 4'b0001 || wr_data[0].rt_data[31:0] !== 32'h11) begin
            bad++; $display("FAIL conflict_first valid=%b tag=%h want=0001/11", wr_valid, wr_data[0].rt_data[31:0]);
        end
`ifdef VRF_WR_SCHED_PERF_EN
        total++; if (perf_conflict_cnt !== 32'd1) begin bad++; $display("FAIL conflict_perf got=%0d want=1", perf_conflict_cnt); end
`endif
        @(negedge clk);
        total++; if (wr_valid !== 4'b0001 || wr_data[0].rt_data[31:0] !== 32'h22) begin
            bad++; $display("FAIL conflict_second valid=%b tag=%h want=0001/22", wr_valid, wr_data[0].rt_data[31:0]);
        end
        req_data[1] = mk(5'd8, 16'h00FF, 32'h33);
        req_data[2] = mk(5'd8, 16'hFF00, 32'h44);
        req_valid   = 6'b000110;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        total++; if (wr_valid !== 4'b0011 || wr_data[0].rt_data[31:0] !== 32'h33 || wr_data[1].rt_data[31:0] !== 32'h44) begin
            bad++; $display("FAIL disjoint_strobe valid=%b tag0=%h tag1=%h want=0011/33/44",
                            wr_valid, wr_data[0].rt_data[31:0], wr_data[1].rt_data[31:0]);
        end
`ifdef VRF_WR_SCHED_PERF_EN
        total++; if (perf_conflict_cnt !== 32'd1) begin bad++; $display("FAIL disjoint_perf got=%0d want=1", perf_conflict_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        req_data[2] = mk(5'd9, 16'hFFFF, 32'hA0);
        req_data[3] = mk(5'd9, 16'hFFFF, 32'h30);
        req_valid   = 6'b001100;
        @(negedge clk);
        req_valid[2] = 1'b0;
        req_data[3]  = mk(5'd9, 16'hFFFF, 32'h31);
        total++; if (req_ready[3] !== 1'b1) begin bad++; $display("FAIL bp_ready_1 got=%b want=1", req_ready[3]); end
        @(negedge clk);
        total++; if (wr_valid !== 4'b0001 || wr_data[0].rt_data[31:0] !== 32'hA0) begin
            bad++; $display("FAIL bp_blocker valid=%b tag=%h want=0001/a0", wr_valid, wr_data[0].rt_data[31:0]);
        end
        total++; if (req_ready[3] !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", req_ready[3]); end
        req_data[3] = mk(5'd9, 16'hFFFF, 32'h32);
        @(negedge clk);
        total++; if (wr_data[0].rt_data[31:0] !== 32'h30 || req_ready[3] !== 1'b1) begin
            bad++; $display("FAIL bp_beat0 tag=%h ready=%b want=30/1", wr_data[0].rt_data[31:0], req_ready[3]);
        end
        @(negedge clk);
        req_valid = '0;
        total++; if (wr_data[0].rt_data[31:0] !== 32'h31) begin bad++; $display("FAIL bp_beat1 tag=%h want=31", wr_data[0].rt_data[31:0]); end
        @(negedge clk);
        total++; if (wr_valid !== 4'b0001 || wr_data[0].rt_data[31:0] !== 32'h32) begin
            bad++; $display("FAIL bp_beat2 valid=%b tag=%h want=0001/32", wr_valid, wr_data[0].rt_data[31:0]);
        end
`ifdef VRF_WR_SCHED_PERF_EN
        total++; if (perf_full_cnt !== 32'd1 || perf_conflict_cnt !== 32'd1) begin
            bad++; $display("FAIL bp_perf full=%0d conflict=%0d want=1/1", perf_full_cnt, perf_conflict_cnt);
        end
`endif
        @(negedge clk);
        total++; if (sched_busy !== 1'b0) begin bad++; $display("FAIL bp_idle busy=%b want=0", sched_busy); end
    endtask

    task automatic test_fairness();
        int cnt [NR];
        int tag;
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        do_reset();
        for (int i = 0; i < NR; i++) req_data[i] = mk(5'(i + 10), 16'hFFFF, 32'(i));
        req_valid = 6'h3F;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if (wr_valid !== 4'b1111) begin bad++; $display("FAIL fair_valid cyc=%0d got=%b want=1111", c, wr_valid); end
            for (int p = 0; p < NW; p++) begin
                tag = int'(wr_data[p].rt_data[7:0]);
                if (wr_valid[p] && tag < NR) cnt[tag]++;
            end
        end
        req_valid = '0;
        for (int i = 0; i < NR; i++) begin
            total++; if (cnt[i] !== 2) begin bad++; $display("FAIL fair_req%0d grants got=%0d want=2", i, cnt[i]); end
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_single();
        test_six();
        test_conflict();
        test_backpressure();
        test_fairness();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
